// File: rtl/data_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder_if
// Description : Load/store request bus between the execute stage and the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_responder_if;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [2:0]  mem_size_i;
    logic        mem_we_i;
    logic        mem_re_i;
    logic [31:0] ram_data_o;
    logic        ram_valid_o;
    logic        misalign_o;
    logic        fault_o;

    modport master (
        output mem_addr_i, mem_data_i, mem_size_i, mem_we_i, mem_re_i,
        input  ram_data_o, ram_valid_o, misalign_o, fault_o
    );

    modport slave (
        input  mem_addr_i, mem_data_i, mem_size_i, mem_we_i, mem_re_i,
        output ram_data_o, ram_valid_o, misalign_o, fault_o
    );
endinterface
`default_nettype wire

// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder
// Description : Word-organised data RAM answering byte/half/word loads and
//               stores with one-cycle load latency and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_responder #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input wire                  clk,
    input wire                  rst,
    data_ram_responder_if.slave bus
);
    localparam logic [2:0] c_SIZE_B  = 3'b000;
    localparam logic [2:0] c_SIZE_H  = 3'b001;
    localparam logic [2:0] c_SIZE_W  = 3'b010;
    localparam logic [2:0] c_SIZE_BU = 3'b100;
    localparam logic [2:0] c_SIZE_HU = 3'b101;

    logic [AW-1:0] w_word_idx;
    logic [1:0]    w_offset;
    logic          w_out_of_range;
    logic          w_misalign;
    logic          w_illegal;
    logic          w_bad;
    logic          w_wr_ok;
    logic          w_wr_bad;
    logic          w_rd_ok;
    logic          w_rd_bad;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rd_word;
    logic [1:0]    r_rd_offset;
    logic [2:0]    r_rd_size;
    logic          r_rd_valid;
    logic          r_misalign;
    logic          r_fault;

    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_word_idx     = bus.mem_addr_i[AW+1:2];
    assign w_offset       = bus.mem_addr_i[1:0];
    assign w_out_of_range = |bus.mem_addr_i[31:AW+2];

    // Unsigned codes are load-only, so a store using them is illegal.
    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        case (bus.mem_size_i)
            c_SIZE_B:  w_misalign = 1'b0;
            c_SIZE_BU: w_illegal  = bus.mem_we_i;
            c_SIZE_H:  w_misalign = w_offset[0];
            c_SIZE_HU: begin
                w_misalign = w_offset[0];
                w_illegal  = bus.mem_we_i;
            end
            c_SIZE_W:  w_misalign = |w_offset;
            default:   w_illegal  = 1'b1;
        endcase
    end

    assign w_bad    = w_misalign | w_out_of_range | w_illegal;
    assign w_wr_ok  = bus.mem_we_i & ~w_bad;
    assign w_wr_bad = bus.mem_we_i & w_bad;
    assign w_rd_ok  = bus.mem_re_i & ~bus.mem_we_i & ~w_bad;
    assign w_rd_bad = bus.mem_re_i & ~bus.mem_we_i & w_bad;

    // ------------------------------------------------------------------
    // Store lane steering: narrow data is replicated across lanes
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.mem_data_i;
        case (bus.mem_size_i)
            c_SIZE_B: begin
                w_be    = 4'b0001 << w_offset;
                w_wdata = {4{bus.mem_data_i[7:0]}};
            end
            c_SIZE_H: begin
                w_be    = w_offset[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.mem_data_i[15:0]}};
            end
            c_SIZE_W: w_be = 4'b1111;
            default:  w_be = 4'b0000;
        endcase
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read capture and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_word   <= '0;
            r_rd_offset <= '0;
            r_rd_size   <= c_SIZE_W;
            r_rd_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok | w_rd_bad;
            r_misalign <= (w_rd_bad | w_wr_bad) & w_misalign;
            r_fault    <= (w_rd_bad | w_wr_bad) & ~w_misalign;
            if (w_rd_ok) begin
                r_rd_word   <= r_mem[w_word_idx];
                r_rd_offset <= w_offset;
                r_rd_size   <= bus.mem_size_i;
            end else if (w_rd_bad) begin
                // A zero word read as W makes the faulting result exactly 0.
                r_rd_word   <= '0;
                r_rd_offset <= '0;
                r_rd_size   <= c_SIZE_W;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    assign w_byte = r_rd_word[{r_rd_offset, 3'b000} +: 8];
    assign w_half = r_rd_offset[1] ? r_rd_word[31:16] : r_rd_word[15:0];

    always_comb begin
        w_load_data = r_rd_word;
        case (r_rd_size)
            c_SIZE_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_SIZE_BU: w_load_data = {24'h000000, w_byte};
            c_SIZE_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_SIZE_HU: w_load_data = {16'h0000, w_half};
            default:   w_load_data = r_rd_word;
        endcase
    end

    assign bus.ram_data_o  = w_load_data;
    assign bus.ram_valid_o = r_rd_valid;
    assign bus.misalign_o  = r_misalign;
    assign bus.fault_o     = r_fault;

endmodule
`default_nettype wire
